fetch_unit: RTL

Instruction fetch front end for the 9-bit single-cycle ISA. It drives the 8-bit address into the combinational-read instruction memory and holds the returned word in an instruction register. It presents that word to decode over a valid/ready handshake. It also owns the program counter, start, branch, halt/done and a retired-instruction counter.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the instruction memory address,
// holds the fetched word and hands it to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned INST_W     = 9,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              branch_en,
    input  logic              branch_abs,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic              done,
    output logic [15:0]       inst_count,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(START_ADDR);

    // Handshake rule: inst_out is transferred to decode on a cycle where
    // inst_valid && inst_ready are both high while running; inst_out, inst_pc
    // and the PC hold whenever inst_valid is high and inst_ready is low.

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              done_q, done_d;
    logic [15:0]       inst_count_q, inst_count_d;

    logic              hs;
    logic              load;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       count_inc;

    always_comb begin
        hs        = inst_valid_q && inst_ready && (state_q == RUN);
        target    = branch_abs ? branch_target : (inst_pc_q + branch_target);
        count_inc = (inst_count_q == 16'hFFFF) ? inst_count_q : (inst_count_q + 16'd1);

        // Branch target is fetched in the handshake cycle, so taken branches are free.
        if (start)
            addr = start_addr;
        else if (hs && halt)
            addr = pc_q;
        else if (hs && branch_en)
            addr = target;
        else
            addr = pc_q;

        load = start || ((state_q == RUN) && !(hs && halt) && (!inst_valid_q || hs));
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        done_d       = done_q;
        inst_count_d = inst_count_q;

        if (start) begin
            state_d      = RUN;
            done_d       = 1'b0;
            inst_count_d = 16'd0;
        end else if (hs && halt) begin
            state_d      = HALTED;
            inst_valid_d = 1'b0;
            done_d       = 1'b1;
            inst_count_d = count_inc;
        end else if (hs) begin
            inst_count_d = count_inc;
        end

        if (load) begin
            inst_out_d   = inst_in;
            inst_pc_d    = addr;
            inst_valid_d = 1'b1;
            pc_d         = addr + PC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= PC_RESET;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            inst_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
            inst_count_q <= inst_count_d;
        end
    end

    assign inst_addr  = addr;
    assign inst_out   = inst_out_q;
    assign inst_valid = inst_valid_q;
    assign inst_pc    = inst_pc_q;
    assign done       = done_q;
    assign inst_count = inst_count_q;
    assign state_dbg  = state_q;

endmodule
